// File: rtl/alu_issue.sv
// alu_issue: decodes MIPS-style ALU instructions into ALU controls and
// queues them in a 2-entry FIFO in front of the ALU.
module alu_issue #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic [width-1:0] rs_data,
  input  logic [width-1:0] rt_data,
  input  logic [15:0]      imm,
  input  logic [4:0]       rt_addr,
  input  logic [4:0]       rd_addr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] alu_operandA,
  output logic [width-1:0] alu_operandB,
  output logic [2:0]       alu_command,
  output logic [4:0]       out_dest,
  output logic             out_reg_write,
  output logic             out_branch,
  output logic             out_illegal
);

  localparam logic [2:0] CMD_ADD = 3'b000;
  localparam logic [2:0] CMD_SUB = 3'b001;
  localparam logic [2:0] CMD_XOR = 3'b010;
  localparam logic [2:0] CMD_SLT = 3'b011;
  localparam logic [2:0] CMD_AND = 3'b100;
  localparam logic [2:0] CMD_NOR = 3'b110;
  localparam logic [2:0] CMD_OR  = 3'b111;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef struct packed {
    logic [width-1:0] op_a;
    logic [width-1:0] op_b;
    logic [2:0]       cmd;
    logic [4:0]       dest;
    logic             reg_write;
    logic             branch;
    logic             illegal;
  } entry_t;

  entry_t           dec_d;
  entry_t           mem_q [2];
  entry_t           head_s;
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic [1:0]       count_d;
  logic             push_s;
  logic             pop_s;
  logic [width-1:0] imm_sext_s;
  logic [width-1:0] imm_zext_s;

  assign imm_sext_s = {{(width-16){imm[15]}}, imm};
  assign imm_zext_s = {{(width-16){1'b0}}, imm};

  // Instruction decode; anything unrecognised leaves an all-zero illegal entry.
  always_comb begin
    dec_d = '0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  dec_d.cmd = CMD_ADD;
          FN_SUB:  dec_d.cmd = CMD_SUB;
          FN_XOR:  dec_d.cmd = CMD_XOR;
          FN_SLT:  dec_d.cmd = CMD_SLT;
          FN_AND:  dec_d.cmd = CMD_AND;
          FN_NOR:  dec_d.cmd = CMD_NOR;
          FN_OR:   dec_d.cmd = CMD_OR;
          default: dec_d.illegal = 1'b1;
        endcase
        if (!dec_d.illegal) begin
          dec_d.op_a      = rs_data;
          dec_d.op_b      = rt_data;
          dec_d.dest      = rd_addr;
          dec_d.reg_write = 1'b1;
        end else begin
          dec_d.cmd = CMD_ADD;
        end
      end
      OP_ADDI, OP_SLTI: begin
        dec_d.cmd       = (opcode == OP_ADDI) ? CMD_ADD : CMD_SLT;
        dec_d.op_a      = rs_data;
        dec_d.op_b      = imm_sext_s;
        dec_d.dest      = rt_addr;
        dec_d.reg_write = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        if (opcode == OP_ANDI) begin
          dec_d.cmd = CMD_AND;
        end else if (opcode == OP_ORI) begin
          dec_d.cmd = CMD_OR;
        end else begin
          dec_d.cmd = CMD_XOR;
        end
        dec_d.op_a      = rs_data;
        dec_d.op_b      = imm_zext_s;
        dec_d.dest      = rt_addr;
        dec_d.reg_write = 1'b1;
      end
      OP_BEQ: begin
        dec_d.cmd    = CMD_SUB;
        dec_d.op_a   = rs_data;
        dec_d.op_b   = rt_data;
        dec_d.branch = 1'b1;
      end
      default: dec_d.illegal = 1'b1;
    endcase
  end

  // in_ready depends only on the registered count, never on out_ready.
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push_s    = in_valid && in_ready;
  assign pop_s     = out_valid && out_ready;

  // Occupancy next-state.
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Count and pointers; reset beats flush, flush beats push/pop.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push_s) begin
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  // Entry storage; contents are don't-care until pushed, outputs are gated.
  always_ff @(posedge clk) begin
    if (push_s && !flush && !reset) begin
      mem_q[wr_ptr_q] <= dec_d;
    end
  end

  assign head_s = mem_q[rd_ptr_q];

  // Head presentation, forced to zero while the buffer is empty.
  always_comb begin
    alu_operandA  = '0;
    alu_operandB  = '0;
    alu_command   = CMD_ADD;
    out_dest      = 5'd0;
    out_reg_write = 1'b0;
    out_branch    = 1'b0;
    out_illegal   = 1'b0;
    if (out_valid) begin
      alu_operandA  = head_s.op_a;
      alu_operandB  = head_s.op_b;
      alu_command   = head_s.cmd;
      out_dest      = head_s.dest;
      out_reg_write = head_s.reg_write;
      out_branch    = head_s.branch;
      out_illegal   = head_s.illegal;
    end else begin
      alu_command = CMD_ADD;
    end
  end

endmodule
